// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Opcode field layout, HALT encoding and a clog2 helper.
package instr_fetch_queue_pkg;

    // Opcode occupies the top OPC_W bits of every instruction word.
    localparam int OPC_W = 5;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Circular buffer for the fetch queue: push, pop, flush, count.
// Pointers wrap naturally because DEPTH is a power of two.
module ifq_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage array; flush discards the write of that cycle.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: fetch PC, epoch squash, HALT stop, queue.
// Optional same-cycle bypass of an empty queue: define IFQ_BYPASS_EN.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH = 4,
    parameter int PC_STEP = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_add,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               halt_out,
    output logic               err
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inf_pc_add;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_inf_epoch;
    logic              r_halted;
    logic              r_err;

    logic [ADDR_W:0]   w_pc_sum;
    logic [CW:0]       w_level;
    logic              w_issue;
    logic              w_resp;
    logic              w_resp_halt;
    logic              w_byp;
    logic              w_deq;
    logic              w_push;
    logic              w_pop;
    logic [DW-1:0]     w_head;
    logic [CW-1:0]     w_count;
    logic              w_empty;

    assign w_pc_sum = {1'b0, r_pc} + (ADDR_W+1)'(PC_STEP);
    assign w_level  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

    // In-flight requests reserve a slot so a response always fits.
    assign w_issue = rst_n & ~stall & ~r_halted & ~redirect
                   & (w_level < (CW+1)'(DEPTH));

    // Responses from an older epoch, or arriving during redirect, are stale.
    assign w_resp = r_inflight & (r_inf_epoch == r_epoch) & ~redirect;
    assign w_resp_halt =
        (imem_rdata[INSTR_W-1 -: OPC_W] == OPC_HALT);

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_empty & w_resp;
`else
    assign w_byp = 1'b0;
`endif

    assign out_valid  = ~redirect & (~w_empty | w_byp);
    assign out_instr  = w_byp ? imem_rdata   : w_head[DW-1 -: INSTR_W];
    assign out_pc_add = w_byp ? r_inf_pc_add : w_head[ADDR_W-1:0];
    assign halt_out   = out_valid
                      & (out_instr[INSTR_W-1 -: OPC_W] == OPC_HALT);

    assign w_deq  = out_valid & out_ready & ~stall & ~redirect;
    assign w_push = w_resp & ~(w_byp & w_deq);
    assign w_pop  = w_deq & ~w_byp;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign err       = r_err;

    ifq_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({imem_rdata, r_inf_pc_add}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Fetch PC: redirect target wins, otherwise step on each issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_issue) begin
            r_pc <= w_pc_sum[ADDR_W-1:0];
        end
    end

    // Epoch and in-flight tag used to squash responses after redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epoch      <= 1'b0;
            r_inflight   <= 1'b0;
            r_inf_epoch  <= 1'b0;
            r_inf_pc_add <= '0;
        end else begin
            if (redirect) r_epoch <= ~r_epoch;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_epoch  <= r_epoch;
                r_inf_pc_add <= w_pc_sum[ADDR_W-1:0];
            end
        end
    end

    // Halt stops issue once a HALT word is accepted; redirect resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_halted <= 1'b0;
        end else if (w_resp && w_resp_halt) begin
            r_halted <= 1'b1;
        end
    end

    // Sticky flag for a PC increment that carried out of the address width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_issue && w_pc_sum[ADDR_W]) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue against a queue-based model.
// Honours IFQ_BYPASS_EN the same way as the design.
module tb_instr_fetch_queue;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH = 4;
    localparam int PC_STEP = 2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pca;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc_add;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt_out;
    logic        err;

    int n_tot = 0;
    int n_bad = 0;

    ent_t        q[$];
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_err;
    logic        m_pv;
    logic [15:0] m_paddr;
    logic [15:0] m_ppca;
    logic [15:0] mem_addr_q;
    logic        halt_en;
    logic [15:0] halt_addr;

    instr_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .PC_STEP  (PC_STEP),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc_add  (out_pc_add),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt_out    (halt_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 16'h0000;
        return (a ^ 16'h35C3) | 16'h0800;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 16'h0000;
        m_halted = 1'b0;
        m_err = 1'b0;
        m_pv = 1'b0;
        m_paddr = '0;
        m_ppca = '0;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input bit st, input bit rdy, input bit rd,
                        input logic [15:0] rpc);
        bit          resp;
        bit          ereq;
        bit          byp;
        bit          ev;
        bit          deq;
        ent_t        hd;
        logic [15:0] w;
        imem_rdata  = word(mem_addr_q);
        stall       = st;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        resp = m_pv && !rd;
        ereq = !st && !m_halted && !rd
             && (q.size() + int'(m_pv) < DEPTH);
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = resp && (q.size() == 0);
`endif
        ev = !rd && (q.size() > 0 || byp);
        w  = word(m_paddr);
        if (byp) hd = ent_t'{w, m_ppca};
        else if (q.size() > 0) hd = q[0];
        else hd = '0;
        chk("req", 32'(imem_req), 32'(ereq));
        chk("addr", 32'(imem_addr), 32'(m_pc));
        chk("valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            chk("instr", 32'(out_instr), 32'(hd.instr));
            chk("pc_add", 32'(out_pc_add), 32'(hd.pca));
            chk("halt", 32'(halt_out), 32'(hd.instr[15:11] == 5'd0));
        end else begin
            chk("halt_idle", 32'(halt_out), 32'(0));
        end
        chk("err", 32'(err), 32'(m_err));
        mem_addr_q = imem_addr;
        deq = ev && rdy && !st && !rd;
        if (rd) begin
            q.delete();
            m_pc = rpc;
            m_halted = 1'b0;
            m_pv = 1'b0;
        end else begin
            if (deq && !byp) void'(q.pop_front());
            if (resp) begin
                if (!(byp && deq)) q.push_back(ent_t'{w, m_ppca});
                if (w[15:11] == 5'd0) m_halted = 1'b1;
            end
            if (ereq) begin
                if (m_pc >= 16'hFFFE) m_err = 1'b1;
                m_paddr = m_pc;
                m_ppca  = m_pc + 16'd2;
                m_pc    = m_pc + 16'd2;
            end
            m_pv = ereq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'(0));
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_halt"}, 32'(halt_out), 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(0));
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_rdata = '0;
        mem_addr_q = '0;
        halt_en = 1'b0;
        halt_addr = 16'h0010;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("rst");
        chk("rst_addr", 32'(imem_addr), 32'(16'h0000));
        rst_n = 1'b1;

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0);

        // Back-pressure fills the queue, then drains.
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

        // Redirect with three queued and one in flight.
        step(0, 0, 1, 16'h0020);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
        step(0, 0, 1, 16'h0040);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

        // HALT at 0x0010, then resume by redirect to 0x0100.
        halt_en = 1'b1;
        step(0, 1, 1, 16'h0008);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
        step(0, 1, 1, 16'h0100);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

        // PC wrap sets the sticky error.
        halt_en = 1'b0;
        step(0, 1, 1, 16'hFFF8);
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0);

        // Random traffic.
        halt_en = 1'b1;
        halt_addr = 16'h0036;
        rand_steps(400);

        // Asynchronous reset mid-run with a request in flight.
        step(0, 1, 0, '0);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);
        rand_steps(300);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
